// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key repeat controller and its event FIFO.
package key_evt_pkg;

  localparam int KEYCODE_W = 9;
  localparam int TIMER_W   = 27;
  localparam int EVT_W     = 2 + KEYCODE_W;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_REPEAT  = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } trk_state_e;

  typedef struct packed {
    evt_type_e             typ;
    logic [KEYCODE_W-1:0]  code;
  } evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO with a registered head that holds its last value when empty.
module key_evt_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = head_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_d   = wr_q;
    rd_d   = rd_q;
    mem_d  = mem_q;
    head_d = head_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + PTR_ONE;
    end
    if (pop_ok) rd_d = rd_q + PTR_ONE;
    // Looking through mem_d lets a push into an empty FIFO land in the head directly.
    if (wr_d != rd_d) head_d = mem_d[rd_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Turns decoder make/break pulses into PRESS/RELEASE events and schedules typematic REPEATs.
module key_repeat_ctrl
  import key_evt_pkg::*;
#(
  parameter int DELAY_CYC  = 50000000,
  parameter int PERIOD_CYC = 10000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [511:0]         key_down,
  input  logic [KEYCODE_W-1:0] last_change,
  input  logic                 key_valid,
  output logic                 evt_valid,
  output logic [1:0]           evt_type,
  output logic [KEYCODE_W-1:0] evt_code,
  input  logic                 evt_ready,
  output logic                 held,
  output logic                 overflow
);

  localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(DELAY_CYC - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(PERIOD_CYC - 1);

  trk_state_e           state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [KEYCODE_W-1:0] active_q, active_d;
  logic                 held_q, held_d;
  logic                 overflow_q, overflow_d;

  logic press, release_evt, push, can_push, fifo_full, fifo_empty;
  evt_t push_evt, head_evt;

  assign press       = key_valid &&  key_down[last_change];
  assign release_evt = key_valid && !key_down[last_change];
  assign evt_valid   = !fifo_empty;
  // Mirrors the FIFO's own accept rule so a rejected push leaves the tracker untouched.
  assign can_push    = !fifo_full || (evt_valid && evt_ready);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    active_d   = active_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_evt   = '{typ: EVT_PRESS, code: last_change};
    if (press) begin
      push = 1'b1;
      if (can_push) begin
        active_d = last_change;
        timer_d  = DELAY_LOAD;
        state_d  = ST_DELAY;
      end
    end else if (release_evt) begin
      push         = 1'b1;
      push_evt.typ = EVT_RELEASE;
      if (can_push && last_change == active_q && state_q != ST_IDLE) state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      if (!key_down[active_q]) begin
        state_d = ST_IDLE;
      end else if (timer_q == '0) begin
        push     = 1'b1;
        push_evt = '{typ: EVT_REPEAT, code: active_q};
        if (can_push) begin
          timer_d = PERIOD_LOAD;
          state_d = ST_REPEAT;
        end
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
    if (push && !can_push) overflow_d = 1'b1;
    held_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      active_q   <= '0;
      held_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      active_q   <= active_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .full      (fifo_full),
    .pop       (evt_ready),
    .empty     (fifo_empty),
    .head      (head_evt)
  );

  assign evt_type = head_evt.typ;
  assign evt_code = head_evt.code;
  assign held     = held_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with an event-level reference model checked every cycle.
module tb_key_repeat_ctrl;

  localparam int DELAY  = 8;
  localparam int PERIOD = 4;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] kd  = '0;
  logic [8:0]   lc  = '0;
  logic         kv  = 1'b0;
  logic         ready = 1'b0;
  logic         evt_valid, held, overflow;
  logic [1:0]   evt_type;
  logic [8:0]   evt_code;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  key_repeat_ctrl #(.DELAY_CYC(DELAY), .PERIOD_CYC(PERIOD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_down(kd), .last_change(lc), .key_valid(kv),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_code(evt_code),
    .evt_ready(ready), .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of events, plus "edges left until the next repeat" for the tracked key.
  logic [10:0] mq[$];
  logic [10:0] m_head = '0;
  bit          m_trk  = 1'b0;
  int          m_left = 0;
  logic [8:0]  m_act  = '0;
  bit          m_ovf  = 1'b0;

  always @(posedge clk) begin
    bit          pop, room, have;
    logic [10:0] e;
    if (rst) begin
      mq.delete();
      m_head = '0; m_trk = 0; m_left = 0; m_act = '0; m_ovf = 0;
    end else begin
      pop  = (mq.size() > 0) && ready;
      room = (mq.size() < DEPTH) || pop;
      have = 0;
      e    = '0;
      if (kv && kd[lc]) begin
        have = 1; e = {2'd0, lc};
        if (room) begin m_trk = 1; m_act = lc; m_left = DELAY; end
      end else if (kv) begin
        have = 1; e = {2'd2, lc};
        if (room && m_trk && lc == m_act) m_trk = 0;
      end else if (m_trk) begin
        if (!kd[m_act]) m_trk = 0;
        else if (m_left == 1) begin
          have = 1; e = {2'd1, m_act};
          if (room) m_left = PERIOD;
        end else m_left--;
      end
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (room) mq.push_back(e);
        else m_ovf = 1;
      end
      if (mq.size() > 0) m_head = mq[0];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_valid",    32'(evt_valid), 32'(mq.size() != 0));
      check("model_head",     32'({evt_type, evt_code}), 32'(m_head));
      check("model_held",     32'(held), 32'(m_trk));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key_press(input logic [8:0] code);
    kd[code] = 1'b1; lc = code; kv = 1'b1;
    tick();
    kv = 1'b0;
  endtask

  task automatic key_release(input logic [8:0] code);
    kd[code] = 1'b0; lc = code; kv = 1'b1;
    tick();
    kv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [1:0] t, input logic [8:0] c);
    check({name, "_valid"}, 32'(evt_valid), 32'd1);
    check({name, "_type"},  32'(evt_type),  32'(t));
    check({name, "_code"},  32'(evt_code),  32'(c));
  endtask

  initial begin
    logic [1:0] drain_t [4];
    logic [8:0] drain_c [4];
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    cmp_on = 1'b1;
    check("reset_valid", 32'(evt_valid), 32'd0);
    check("reset_type",  32'(evt_type),  32'd0);
    check("reset_code",  32'(evt_code),  32'd0);
    check("reset_held",  32'(held),      32'd0);
    check("reset_ovf",   32'(overflow),  32'd0);

    // 1: press, six repeats, release at +30
    ready = 1'b1;
    key_press(9'h01C);
    expect_head("t1_press", 2'd0, 9'h01C);
    idle(7);
    check("t1_no_early_repeat", 32'(evt_valid), 32'd0);
    idle(1);
    expect_head("t1_first_repeat", 2'd1, 9'h01C);
    idle(21);
    key_release(9'h01C);
    expect_head("t1_release", 2'd2, 9'h01C);
    check("t1_held_drop", 32'(held), 32'd0);
    idle(2);

    // 2: second press re-targets and restarts the delay
    key_press(9'h01C);
    idle(4);
    key_press(9'h11D);
    expect_head("t2_press_ext", 2'd0, 9'h11D);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t2_no_repeat", 32'(evt_valid), 32'd0);
    end
    tick();
    expect_head("t2_repeat_ext", 2'd1, 9'h11D);
    key_release(9'h11D);
    key_release(9'h01C);
    idle(2);

    // 3: another key pressed and released during the delay stops tracking
    key_press(9'h01C);
    idle(2);
    key_press(9'h023);
    key_release(9'h023);
    expect_head("t3_release", 2'd2, 9'h023);
    check("t3_held", 32'(held), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t3_quiet", 32'(evt_valid), 32'd0);
    end
    key_release(9'h01C);
    idle(2);

    // 4: overflow with the consumer stalled
    ready = 1'b0;
    key_press(9'h01C);
    idle(39);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_held", 32'(held), 32'd1);
    key_release(9'h01C);
    check("t4_held_after_dropped_release", 32'(held), 32'd1);
    tick();
    check("t4_held_defensive", 32'(held), 32'd0);
    ready = 1'b1;
    drain_t = '{2'd0, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      expect_head("t4_drain", drain_t[i], 9'h01C);
      tick();
    end
    check("t4_empty", 32'(evt_valid), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 5: push into a full FIFO in the pop cycle is accepted
    do_reset();
    check("t5_ovf_cleared", 32'(overflow), 32'd0);
    ready = 1'b0;
    key_press(9'h01C);
    key_release(9'h01C);
    key_press(9'h023);
    key_release(9'h023);
    expect_head("t5_full_head", 2'd0, 9'h01C);
    ready = 1'b1;
    key_press(9'h01C);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    drain_t = '{2'd2, 2'd0, 2'd2, 2'd0};
    drain_c = '{9'h01C, 9'h023, 9'h023, 9'h01C};
    for (int i = 0; i < 4; i++) begin
      expect_head("t5_drain", drain_t[i], drain_c[i]);
      tick();
    end
    check("t5_empty", 32'(evt_valid), 32'd0);
    key_release(9'h01C);
    idle(2);

    // 6: reset mid-repeat flushes without a RELEASE
    ready = 1'b0;
    key_press(9'h01C);
    idle(9);
    expect_head("t6_queued", 2'd0, 9'h01C);
    check("t6_held_before", 32'(held), 32'd1);
    do_reset();
    check("t6_valid", 32'(evt_valid), 32'd0);
    check("t6_held",  32'(held),      32'd0);
    check("t6_ovf",   32'(overflow),  32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_quiet", 32'(evt_valid), 32'd0);
    end
    key_release(9'h01C);
    expect_head("t6_late_release", 2'd2, 9'h01C);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
